// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, sequences imem requests/responses and buffers one instruction for decode.
// Redirects use branch > jalr > jal priority; a fetch already accepted on the wrong path is killed on return.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_taken,
    input  logic        jalr,
    input  logic        jal,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] jal_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic [15:0] kill_count
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic        r_kill, w_kill_nxt;
    logic [15:0] r_kill_count, w_kill_count_nxt;
    logic        w_redirect;
    logic [31:0] w_target;
    assign w_redirect     = branch_taken | jalr | jal;
    assign w_target       = branch_taken ? branch_target : jalr ? jalr_target : jal_target;
    assign imem_req_valid = r_state == REQ;
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign kill_count     = r_kill_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_kill_count <= 16'h0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= NOP_INSTR;
            r_if_pc      <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_kill_count <= w_kill_count_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_pc      <= w_if_pc_nxt;
        end
    end
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_kill_nxt       = r_kill;
        w_kill_count_nxt = r_kill_count;
        w_if_valid_nxt   = r_if_valid;
        w_if_instr_nxt   = r_if_instr;
        w_if_pc_nxt      = r_if_pc;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (w_redirect) w_pc_nxt = w_target;
            end
            REQ: begin
                if (w_redirect) w_pc_nxt = w_target;
                if (imem_req_ready) begin
                    w_state_nxt = WAIT;
                    w_kill_nxt  = w_redirect;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (!r_kill && !w_redirect) begin
                        w_state_nxt    = OUT;
                        w_if_valid_nxt = 1'b1;
                        w_if_instr_nxt = imem_rsp_data;
                        w_if_pc_nxt    = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                    end else begin
                        // pc already holds the target when the kill was set earlier
                        w_state_nxt      = REQ;
                        w_kill_nxt       = 1'b0;
                        w_kill_count_nxt = &r_kill_count ? r_kill_count : r_kill_count + 16'd1;
                        w_pc_nxt         = w_redirect ? w_target : r_pc;
                    end
                end else if (w_redirect) begin
                    w_pc_nxt   = w_target;
                    w_kill_nxt = 1'b1;
                end
            end
            OUT: begin
                if (w_redirect || if_ready) begin
                    w_state_nxt    = REQ;
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                end
                if (w_redirect) w_pc_nxt = w_target;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: cycle-by-cycle vector table plus a variable-latency fetch sequence.
module tb_fetch_sequencer;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        branch_taken = 1'b0;
    logic        jalr = 1'b0;
    logic        jal = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] jalr_target = 32'h0;
    logic [31:0] jal_target = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
    logic [15:0] kill_count;
    int checks = 0;
    int errors = 0;
    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .branch_taken(branch_taken), .jalr(jalr), .jal(jal),
        .branch_target(branch_target), .jalr_target(jalr_target), .jal_target(jal_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .pc(pc), .kill_count(kill_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        rst, rdy, rv, br, jr, jl, ir;
        logic [31:0] rd, bt, jt, lt;
        logic        e_rv, e_ifv;
        logic [31:0] e_addr, e_instr, e_ifpc;
        logic [15:0] e_kc;
    } vec_t;
    vec_t vq[$];
    task automatic add(input logic r, rdy, rv, input logic [31:0] rd, input logic br, jr, jl,
                       input logic [31:0] bt, jt, lt, input logic ir,
                       input logic e_rv, input logic [31:0] e_addr, input logic e_ifv,
                       input logic [31:0] e_instr, e_ifpc, input logic [15:0] e_kc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.br = br; v.jr = jr; v.jl = jl;
        v.bt = bt; v.jt = jt; v.lt = lt; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_instr = e_instr; v.e_ifpc = e_ifpc; v.e_kc = e_kc;
        vq.push_back(v);
    endtask
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        //  rst rdy rv data          br jr jl bt         jt            lt          ir  erv addr          ifv instr         ifpc          kc
        add(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 1, 32'h00500093, 0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h4,        1, 32'h00500093, 32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      1,  1, 32'h4,        0, NOP,          32'h0,        0);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h4,        0, NOP,          32'h0,        0);
        add(0, 0, 1, 32'h00a00113, 0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h8,        1, 32'h00a00113, 32'h4,        0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 32'h0,    0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h8,        1, 32'h00a00113, 32'h4,        0);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      1,  1, 32'h8,        0, NOP,          32'h4,        0);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h8,        0, NOP,          32'h4,        0);
        add(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,     32'h0,        32'h100,    0,  0, 32'h100,      0, NOP,          32'h4,        0);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h100,      0, NOP,          32'h4,        0);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h100,      0, NOP,          32'h4,        0);
        add(0, 0, 1, 32'hdeadbeef, 0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h100,      0, NOP,          32'h4,        1);
        add(0, 0, 0, 32'h0,        1, 1, 1, 32'h40,    32'h80,       32'hC0,     0,  1, 32'h40,       0, NOP,          32'h4,        1);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h40,       0, NOP,          32'h4,        1);
        add(0, 0, 1, 32'h11111111, 0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h44,       1, 32'h11111111, 32'h40,       1);
        add(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,     32'hFFFFFFFC, 32'h0,      0,  1, 32'hFFFFFFFC, 0, NOP,          32'h40,       1);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'hFFFFFFFC, 0, NOP,          32'h40,       1);
        add(0, 0, 1, 32'h22222222, 0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        1, 32'h22222222, 32'hFFFFFFFC, 1);
        add(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      1,  1, 32'h0,        0, NOP,          32'hFFFFFFFC, 1);
        add(0, 1, 0, 32'h0,        1, 0, 0, 32'h200,   32'h0,        32'h0,      0,  0, 32'h200,      0, NOP,          32'hFFFFFFFC, 1);
        add(0, 0, 1, 32'h33,       0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h200,      0, NOP,          32'hFFFFFFFC, 2);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h200,      0, NOP,          32'hFFFFFFFC, 2);
        add(0, 0, 1, 32'h44,       0, 0, 1, 32'h0,     32'h0,        32'h300,    0,  1, 32'h300,      0, NOP,          32'hFFFFFFFC, 3);
        add(0, 0, 1, 32'h55,       0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h300,      0, NOP,          32'hFFFFFFFC, 3);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h300,      0, NOP,          32'hFFFFFFFC, 3);
        add(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 1, 32'h66,       0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 1, 32'h67,       0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  1, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 1, 32'h77,       0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h4,        1, 32'h77,       32'h0,        0);
        add(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        32'h0,      0,  0, 32'h0,        0, NOP,          32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,     32'h0,        32'h500,    0,  1, 32'h500,      0, NOP,          32'h0,        0);
        foreach (vq[i]) begin
            rst = vq[i].rst; imem_req_ready = vq[i].rdy; imem_rsp_valid = vq[i].rv; imem_rsp_data = vq[i].rd;
            branch_taken = vq[i].br; jalr = vq[i].jr; jal = vq[i].jl;
            branch_target = vq[i].bt; jalr_target = vq[i].jt; jal_target = vq[i].lt; if_ready = vq[i].ir;
            tick();
            chk("req_valid", i, {31'h0, imem_req_valid}, {31'h0, vq[i].e_rv});
            chk("req_addr", i, imem_req_addr, vq[i].e_addr);
            chk("pc", i, pc, vq[i].e_addr);
            chk("if_valid", i, {31'h0, if_valid}, {31'h0, vq[i].e_ifv});
            chk("if_instr", i, if_instr, vq[i].e_instr);
            chk("if_pc", i, if_pc, vq[i].e_ifpc);
            chk("kill_count", i, {16'h0, kill_count}, {16'h0, vq[i].e_kc});
        end
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        branch_taken = 1'b0; jalr = 1'b0; jal = 1'b0; if_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [31:0] a;
            n = 0;
            while (!imem_req_valid && n < 20) begin
                tick();
                n++;
            end
            chk("seq_req_timeout", k, {31'h0, imem_req_valid}, 32'h1);
            chk("seq_addr", k, imem_req_addr, 32'(4 * k));
            a = imem_req_addr;
            imem_req_ready = 1'b1;
            tick();
            imem_req_ready = 1'b0;
            repeat (k + 1) begin
                tick();
                chk("seq_wait_idle", k, {30'h0, imem_req_valid, if_valid}, 32'h0);
            end
            imem_rsp_valid = 1'b1;
            imem_rsp_data = a ^ 32'hA5A5_0000;
            tick();
            imem_rsp_valid = 1'b0;
            chk("seq_instr", k, if_instr, a ^ 32'hA5A5_0000);
            chk("seq_if_pc", k, if_pc, a);
            repeat (k) begin
                tick();
                chk("seq_hold", k, {31'h0, if_valid & ~imem_req_valid}, 32'h1);
            end
            if_ready = 1'b1;
            tick();
            if_ready = 1'b0;
            chk("seq_drain", k, {31'h0, if_valid}, 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
